// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with fetch-to-EX prediction tracking
// Predicts fetch redirects, carries each prediction to EX and flags mispredictions.
module branch_target_buffer #(
  parameter int          ENTRIES = 16,
  parameter logic [6:0]  B_OP    = 7'b1100011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_pc,
  input  logic        pred_dir,
  input  logic        stall,
  input  logic [31:0] EX_pc,
  input  logic [6:0]  EX_op,
  input  logic        EX_taken,
  input  logic [31:0] EX_target,
  output logic        IF_pred_taken,
  output logic [31:0] IF_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic [31:0]      if_pc_plus4;
  logic             hit;

  logic             ifid_taken_q;
  logic [31:0]      ifid_target_q;
  logic             idex_taken_q;
  logic [31:0]      idex_target_q;

  logic             ex_is_branch;
  logic             ex_write;

  assign if_idx      = IF_pc[IDX_W+1:2];
  assign if_tag      = IF_pc[31:IDX_W+2];
  assign ex_idx      = EX_pc[IDX_W+1:2];
  assign ex_tag      = EX_pc[31:IDX_W+2];
  assign if_pc_plus4 = IF_pc + 32'd4;

  // Array reads happen before the edge, so a same-cycle write is seen only next cycle.
  assign hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign IF_pred_taken  = hit && pred_dir;
  assign IF_pred_target = IF_pred_taken ? target_q[if_idx] : if_pc_plus4;

  assign ex_is_branch = (EX_op == B_OP);
  assign ex_write     = ex_is_branch && EX_taken;

  assign mispredict  = ex_is_branch &&
                       ((EX_taken != idex_taken_q) ||
                        (EX_taken && idex_taken_q && (EX_target != idex_target_q)));
  assign redirect_pc = EX_taken ? EX_target : (EX_pc + 32'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (ex_write) begin
      valid_q[ex_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are ignored until the valid bit is set.
  always_ff @(posedge clk) begin
    if (ex_write) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= EX_target;
    end
  end

  // A flush outranks the stall hold: a wrong-path prediction must never reach EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_taken_q  <= 1'b0;
      ifid_target_q <= '0;
      idex_taken_q  <= 1'b0;
      idex_target_q <= '0;
    end else if (mispredict) begin
      ifid_taken_q  <= 1'b0;
      ifid_target_q <= '0;
      idex_taken_q  <= 1'b0;
      idex_target_q <= '0;
    end else if (stall) begin
      idex_taken_q  <= 1'b0;
      idex_target_q <= '0;
    end else begin
      ifid_taken_q  <= IF_pred_taken;
      ifid_target_q <= IF_pred_target;
      idex_taken_q  <= ifid_taken_q;
      idex_target_q <= ifid_target_q;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer
module tb_branch_target_buffer;

  localparam logic [6:0] BOP = 7'b1100011;
  localparam logic [6:0] NOP = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_pc;
  logic        pred_dir;
  logic        stall;
  logic [31:0] EX_pc;
  logic [6:0]  EX_op;
  logic        EX_taken;
  logic [31:0] EX_target;
  logic        IF_pred_taken;
  logic [31:0] IF_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  typedef struct {
    string       name;
    bit          exp_pt;
    logic [31:0] exp_tgt;
    bit          exp_mp;
    logic [31:0] exp_rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  branch_target_buffer #(.ENTRIES(16), .B_OP(BOP)) dut (
    .clk(clk), .rst(rst), .IF_pc(IF_pc), .pred_dir(pred_dir), .stall(stall),
    .EX_pc(EX_pc), .EX_op(EX_op), .EX_taken(EX_taken), .EX_target(EX_target),
    .IF_pred_taken(IF_pred_taken), .IF_pred_target(IF_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".pred_taken"}, {31'd0, IF_pred_taken}, {31'd0, e.exp_pt});
      chk({e.name, ".pred_target"}, IF_pred_target, e.exp_tgt);
      chk({e.name, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.exp_mp});
      if (e.exp_mp) chk({e.name, ".redirect_pc"}, redirect_pc, e.exp_rd);
    end
  end

  task automatic step(string name, bit r, bit stl, logic [31:0] ipc, bit dir,
                      logic [6:0] op, logic [31:0] epc, bit tk, logic [31:0] etg,
                      bit ept, logic [31:0] eptg, bit emp, logic [31:0] erd);
    exp_t e;
    rst = r; stall = stl; IF_pc = ipc; pred_dir = dir;
    EX_op = op; EX_pc = epc; EX_taken = tk; EX_target = etg;
    e.name = name; e.exp_pt = ept; e.exp_tgt = eptg; e.exp_mp = emp; e.exp_rd = erd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; IF_pc = 32'h100; pred_dir = 1'b1;
    EX_op = NOP; EX_pc = '0; EX_taken = 1'b0; EX_target = '0;
    @(posedge clk);
    #1;
    //   name          rst stl IF_pc          dir op   EX_pc        tk EX_tgt   pt tgt            mp rd
    step("rst_bop",     1, 0, 32'h100,        1, BOP, 32'h100,     1, 32'h80,   0, 32'h104,       1, 32'h80);
    step("rst_idle",    1, 0, 32'h100,        1, NOP, 32'h0,       0, 32'h0,    0, 32'h104,       0, 32'h0);
    step("cold",        0, 0, 32'h100,        1, NOP, 32'h0,       0, 32'h0,    0, 32'h104,       0, 32'h0);
    step("alloc",       0, 0, 32'h200,        1, BOP, 32'h100,     1, 32'h80,   0, 32'h204,       1, 32'h80);
    step("hit",         0, 0, 32'h100,        1, NOP, 32'h0,       0, 32'h0,    1, 32'h80,        0, 32'h0);
    step("hit_dir0",    0, 0, 32'h100,        0, NOP, 32'h0,       0, 32'h0,    0, 32'h104,       0, 32'h0);
    step("correct",     0, 0, 32'h300,        0, BOP, 32'h100,     1, 32'h80,   0, 32'h304,       0, 32'h0);
    step("dir_miss",    0, 0, 32'h100,        1, BOP, 32'h100,     1, 32'h80,   1, 32'h80,        1, 32'h80);
    step("refetch",     0, 0, 32'h100,        1, NOP, 32'h0,       0, 32'h0,    1, 32'h80,        0, 32'h0);
    step("fill",        0, 0, 32'h400,        1, NOP, 32'h0,       0, 32'h0,    0, 32'h404,       0, 32'h0);
    step("nt_miss",     0, 0, 32'h500,        1, BOP, 32'h100,     0, 32'h80,   0, 32'h504,       1, 32'h104);
    step("idex_bub",    0, 0, 32'h100,        1, BOP, 32'h100,     1, 32'h90,   1, 32'h80,        1, 32'h90);
    step("ifid_bub",    0, 0, 32'h100,        1, BOP, 32'h100,     1, 32'h90,   1, 32'h90,        1, 32'h90);
    step("alias_wr",    0, 0, 32'h140,        1, BOP, 32'h140,     1, 32'h60,   0, 32'h144,       1, 32'h60);
    step("alias_old",   0, 0, 32'h100,        1, NOP, 32'h0,       0, 32'h0,    0, 32'h104,       0, 32'h0);
    step("alias_new",   0, 0, 32'h140,        1, NOP, 32'h0,       0, 32'h0,    1, 32'h60,        0, 32'h0);
    step("stall1",      0, 1, 32'h600,        0, NOP, 32'h0,       0, 32'h0,    0, 32'h604,       0, 32'h0);
    step("stall2",      0, 1, 32'h600,        0, NOP, 32'h0,       0, 32'h0,    0, 32'h604,       0, 32'h0);
    step("unstall",     0, 0, 32'h700,        0, NOP, 32'h0,       0, 32'h0,    0, 32'h704,       0, 32'h0);
    step("held_pred",   0, 0, 32'h140,        1, BOP, 32'h140,     1, 32'h60,   1, 32'h60,        0, 32'h0);
    step("mp_stall",    0, 1, 32'h140,        1, BOP, 32'h140,     1, 32'h60,   1, 32'h60,        1, 32'h60);
    step("post_flush",  0, 0, 32'h800,        0, NOP, 32'h0,       0, 32'h0,    0, 32'h804,       0, 32'h0);
    step("flush_won",   0, 0, 32'h800,        0, BOP, 32'h140,     1, 32'h60,   0, 32'h804,       1, 32'h60);
    step("rst_mid",     1, 0, 32'h140,        1, BOP, 32'h180,     1, 32'h20,   0, 32'h144,       1, 32'h20);
    step("rst_lost",    0, 0, 32'h180,        1, NOP, 32'h0,       0, 32'h0,    0, 32'h184,       0, 32'h0);
    step("rst_clear",   0, 0, 32'h140,        1, NOP, 32'h0,       0, 32'h0,    0, 32'h144,       0, 32'h0);
    step("wrap",        0, 0, 32'hFFFFFFFC,   0, NOP, 32'h200,     1, 32'h10,   0, 32'h0,         0, 32'h0);
    step("nonb_nowr",   0, 0, 32'h200,        1, NOP, 32'h0,       0, 32'h0,    0, 32'h204,       0, 32'h0);
    step("nt_redir",    0, 0, 32'h200,        1, BOP, 32'hFFFFFFFC,1, 32'h40,   0, 32'h204,       1, 32'h40);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
